// File: rtl/adc_apb_scheduler_pkg.sv
// Shared definitions for the ADC APB read-port scheduler: FSM state encoding and
// the ADC register map.
package adc_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } state_e;

  localparam logic [7:0] ADC_ADDR_TEMP = 8'h40;
  localparam logic [7:0] ADC_ADDR_VCC  = 8'h41;

endpackage

// File: rtl/adc_apb_scheduler_if.sv
// Requester-side and ADC APB-side signals of the scheduler. The master modport is
// the scheduler's view; the slave modport is the environment (requesters + ADC).
interface adc_apb_scheduler_if #(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;
  logic                    rsp_err;
  logic                    busy;
  logic [ADDR_W-1:0]       apb_paddr;
  logic                    apb_psel;
  logic                    apb_penable;
  logic                    apb_pready;
  logic [DATA_W-1:0]       apb_prdata;

  modport master (
    input  req_valid, req_addr, apb_pready, apb_prdata,
    output req_ready, rsp_valid, rsp_data, rsp_err, busy, apb_paddr, apb_psel, apb_penable
  );

  modport slave (
    output req_valid, req_addr, apb_pready, apb_prdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err, busy, apb_paddr, apb_psel, apb_penable
  );

endinterface

// File: rtl/adc_apb_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or after ptr,
// wrapping at N.
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int unsigned j;

  // Scan from the farthest candidate back to ptr so the nearest one is written last.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = IW'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_apb_scheduler.sv
// Shares the ADC APB read port between N_REQ requesters: round-robin grant, SETUP/ACCESS
// sequencing with timeout abort, and a one-cycle response pulse to the owner.
module adc_apb_scheduler
  import adc_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input logic                clk,
  input logic                rst,
  adc_apb_scheduler_if.master bus
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, gnt_idx_q, arb_idx;
  logic [N_REQ-1:0]  arb_grant;
  logic              arb_any;
  logic [CW-1:0]     tcnt_q;
  logic              tmo_hit;
  logic [ADDR_W-1:0] paddr_q;
  logic              psel_q, penable_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;

  rr_arbiter #(
    .N (N_REQ),
    .IW(IW)
  ) u_arb (
    .req  (bus.req_valid),
    .ptr  (rr_ptr_q),
    .grant(arb_grant),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  assign tmo_hit = (tcnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (arb_any) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (bus.apb_pready || tmo_hit) state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      gnt_idx_q  <= '0;
      tcnt_q     <= '0;
      paddr_q    <= '0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      // APB strobes decoded from the next state so they are clean flop outputs.
      psel_q    <= (state_d == StSetup) || (state_d == StAccess);
      penable_q <= (state_d == StAccess);
      if (state_q == StIdle && arb_any) begin
        gnt_idx_q <= arb_idx;
        paddr_q   <= bus.req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
        rr_ptr_q  <= (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + IW'(1);
      end
      if (state_q == StSetup) tcnt_q <= '0;
      if (state_q == StAccess) begin
        if (bus.apb_pready) begin
          rsp_data_q <= bus.apb_prdata;
          rsp_err_q  <= 1'b0;
        end else if (tmo_hit) begin
          rsp_data_q <= '0;
          rsp_err_q  <= 1'b1;
        end else begin
          tcnt_q <= tcnt_q + CW'(1);
        end
      end
    end
  end

  // Grant is withheld while reset is asserted so every output reads zero.
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    if (state_q == StIdle && !rst) bus.req_ready = arb_grant;
    for (int i = 0; i < int'(N_REQ); i++) begin
      bus.rsp_valid[i] = (state_q == StResp) && (gnt_idx_q == IW'(i));
    end
  end

  assign bus.busy        = (state_q != StIdle);
  assign bus.apb_paddr   = paddr_q;
  assign bus.apb_psel    = psel_q;
  assign bus.apb_penable = penable_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_adc_apb_scheduler.sv
// Scoreboard bench for adc_apb_scheduler: random requesters and ADC responder, with a
// round-robin/transaction reference model and a decoupled response monitor.
module tb_adc_apb_scheduler;
  import adc_sched_pkg::*;

  localparam int N    = 2;
  localparam int AW   = 8;
  localparam int DW   = 16;
  localparam int TO   = 4;
  localparam int TO_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  adc_apb_scheduler_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
  adc_apb_scheduler_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) wbus ();

  adc_apb_scheduler #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  adc_apb_scheduler #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO_W)) u_dut_w (
    .clk(clk),
    .rst(rst),
    .bus(wbus)
  );

  logic          rv [N];
  logic [AW-1:0] ra [N];
  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]         = rv[i];
      bus.req_addr[i*AW +: AW] = ra[i];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          owner;
    logic [7:0]  addr;
    int          gcyc;
    int          d;
    logic [15:0] data;
    int          pen;
  } txn_t;

  txn_t exp_q[$];
  int   gseq[$];

  // ADC responder: picks a pready delay d per transaction (d >= TO means never).
  int          force_d = -1;
  logic [15:0] force_data = '0;
  int          acnt = 0;
  int          cur_d = 0;
  logic [15:0] cur_data = '0;
  always @(negedge clk) begin
    bus.apb_pready = 1'b0;
    bus.apb_prdata = 16'($urandom);
    if (!rst && bus.apb_psel && !bus.apb_penable) begin
      bus.apb_pready = 1'($urandom);
      cur_d    = (force_d >= 0) ? force_d : int'($urandom_range(0, TO + 1));
      cur_data = (force_d >= 0) ? force_data : 16'($urandom);
      acnt     = 0;
      if (exp_q.size() == 0) begin
        check("setup_without_grant", 32'(bus.apb_paddr), 32'hFFFF_FFFF);
      end else begin
        check("paddr", 32'(bus.apb_paddr), 32'(exp_q[0].addr));
        exp_q[0].d    = cur_d;
        exp_q[0].data = cur_data;
        exp_q[0].pen  = 0;
      end
    end else if (!rst && bus.apb_psel && bus.apb_penable) begin
      if (acnt == cur_d) begin
        bus.apb_pready = 1'b1;
        bus.apb_prdata = cur_data;
      end
      acnt++;
      if (exp_q.size() > 0) exp_q[0].pen = acnt;
    end
  end

  // Monitor + reference model: the DUT may grant only when no transaction is open and at
  // least one cycle has passed since the last response; winner is the first requester at
  // or after the model's pointer.
  int ptr = 0;
  bit outst = 0;
  int last_rsp = -10;
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    int w, epen, eerr;
    logic [15:0] edat;
    txn_t t;
    if (rst) begin
      exp_q.delete();
      outst = 0;
      ptr = 0;
      last_rsp = -10;
    end else begin
      exp_rdy = '0;
      w = -1;
      if (!outst && cyc > last_rsp) begin
        for (int k = 0; k < N; k++) if (w < 0 && rv[(ptr + k) % N]) w = (ptr + k) % N;
      end
      if (w >= 0) exp_rdy[w] = 1'b1;
      if (exp_rdy != '0 || bus.req_ready != '0)
        check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      if (w >= 0) begin
        t.owner = w; t.addr = ra[w]; t.gcyc = cyc; t.d = TO + 1; t.data = '0; t.pen = 0;
        exp_q.push_back(t);
        gseq.push_back(w);
        outst = 1;
        ptr = (w + 1) % N;
      end
      if (bus.rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          check("rsp_without_txn", 32'(bus.rsp_valid), 32'h0);
        end else begin
          t    = exp_q.pop_front();
          epen = (t.d < TO) ? t.d + 1 : TO;
          edat = (t.d < TO) ? t.data : 16'h0;
          eerr = (t.d < TO) ? 0 : 1;
          check("rsp_valid_owner", 32'(bus.rsp_valid), 32'(1 << t.owner));
          check("rsp_data", 32'(bus.rsp_data), 32'(edat));
          check("rsp_err", 32'(bus.rsp_err), 32'(eerr));
          check("penable_cycles", 32'(t.pen), 32'(epen));
          check("latency", 32'(cyc - t.gcyc), 32'(2 + epen));
        end
        outst = 0;
        last_rsp = cyc;
      end
    end
  end

  task automatic requester(input int id, input int nreq);
    int gap, drop_after, waited;
    bit got;
    for (int n = 0; n < nreq; n++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(posedge clk);
      #1;
      case ($urandom_range(0, 2))
        0:       ra[id] = ADC_ADDR_TEMP;
        1:       ra[id] = ADC_ADDR_VCC;
        default: ra[id] = 8'($urandom);
      endcase
      rv[id] = 1'b1;
      drop_after = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 1000;
      waited = 0;
      got = 0;
      while (!got && waited < drop_after && waited < 200) begin
        @(negedge clk);
        got = bus.req_ready[id];
        @(posedge clk);
        #1;
        waited++;
      end
      if (!got && drop_after == 1000) check("req_starved", 32'(waited), 32'h0);
      rv[id] = 1'b0;
    end
  endtask

  initial begin
    int pen, seen1;
    for (int i = 0; i < N; i++) begin
      rv[i] = 1'b0;
      ra[i] = '0;
    end
    wbus.req_valid = '0;
    wbus.req_addr = '0;
    wbus.apb_pready = 1'b0;
    wbus.apb_prdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_psel", 32'(bus.apb_psel), 32'h0);
    check("rst_penable", 32'(bus.apb_penable), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_outputs", 32'({bus.rsp_data, bus.rsp_err, bus.apb_paddr}), 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Single read with immediate pready
    @(posedge clk); #1;
    force_d = 0; force_data = 16'h1A2B;
    ra[0] = ADC_ADDR_TEMP; rv[0] = 1'b1;
    @(negedge clk);
    check("t1_req_ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1 rv[0] = 1'b0;
    @(negedge clk);
    check("t1_setup", 32'({bus.apb_psel, bus.apb_penable}), 32'h2);
    @(negedge clk);
    check("t1_access", 32'({bus.apb_psel, bus.apb_penable}), 32'h3);
    @(negedge clk);
    check("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("t1_rsp_data", 32'(bus.rsp_data), 32'h1A2B);
    check("t1_rsp_err", 32'(bus.rsp_err), 32'h0);
    check("t1_psel_off", 32'(bus.apb_psel), 32'h0);

    // Contention: both requesters held, grants must alternate
    @(posedge clk); #1;
    gseq.delete();
    ra[0] = ADC_ADDR_TEMP; ra[1] = ADC_ADDR_VCC;
    rv[0] = 1'b1; rv[1] = 1'b1;
    repeat (24) @(posedge clk);
    #1 rv[0] = 1'b0; rv[1] = 1'b0;
    repeat (10) @(posedge clk);
    check("t2_grants_min", 32'(gseq.size() >= 4), 32'h1);
    for (int k = 1; k < gseq.size(); k++) check("t2_alternate", 32'(gseq[k] != gseq[k-1]), 32'h1);

    // Timeout: pready never comes, then a normal read follows
    force_d = TO + 1;
    @(posedge clk); #1 ra[1] = ADC_ADDR_VCC; rv[1] = 1'b1;
    pen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.req_ready[1]) begin @(posedge clk); #1 rv[1] = 1'b0; @(negedge clk); end
      if (bus.apb_penable) pen++;
      if (bus.rsp_valid != '0) break;
    end
    check("t4_access_cycles", 32'(pen), 32'(TO));
    check("t4_rsp_err", 32'(bus.rsp_err), 32'h1);
    check("t4_rsp_data", 32'(bus.rsp_data), 32'h0);
    force_d = 1; force_data = 16'h5A5A;
    @(posedge clk); #1 ra[0] = ADC_ADDR_TEMP; rv[0] = 1'b1;
    @(posedge clk); #1 rv[0] = 1'b0;
    repeat (8) @(posedge clk);
    check("t4_after_data", 32'(bus.rsp_data), 32'h5A5A);
    check("t4_after_err", 32'(bus.rsp_err), 32'h0);

    // Dropped request: requester 1 pulses while requester 0 is in service
    force_d = 3;
    gseq.delete();
    @(posedge clk); #1 ra[0] = ADC_ADDR_TEMP; rv[0] = 1'b1;
    @(posedge clk); #1 rv[0] = 1'b0;
    @(posedge clk); #1 ra[1] = ADC_ADDR_VCC; rv[1] = 1'b1;
    @(posedge clk); #1 rv[1] = 1'b0;
    seen1 = 0;
    repeat (10) begin @(negedge clk); if (bus.req_ready[1]) seen1++; end
    check("t6_no_ready1", 32'(seen1), 32'h0);
    check("t6_grants", 32'(gseq.size()), 32'h1);

    // Wait states on the second instance: pready after 5 ACCESS cycles
    @(posedge clk); #1;
    wbus.req_addr = {8'h00, ADC_ADDR_VCC};
    wbus.req_valid = 2'b01;
    @(negedge clk);
    check("t3_req_ready", 32'(wbus.req_ready), 32'h1);
    @(posedge clk); #1 wbus.req_valid = 2'b00;
    pen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      wbus.apb_pready = 1'b0;
      if (wbus.apb_penable) begin
        pen++;
        if (pen == 5) begin wbus.apb_pready = 1'b1; wbus.apb_prdata = 16'h0777; end
      end
      if (wbus.rsp_valid != '0) break;
    end
    check("t3_penable_cycles", 32'(pen), 32'h5);
    check("t3_rsp_valid", 32'(wbus.rsp_valid), 32'h1);
    check("t3_rsp_data", 32'(wbus.rsp_data), 32'h0777);
    check("t3_rsp_err", 32'(wbus.rsp_err), 32'h0);

    // Randomized traffic
    force_d = -1;
    fork
      requester(0, 30);
      requester(1, 30);
    join
    repeat (10) @(posedge clk);

    // Reset during the second ACCESS cycle
    force_d = TO + 1;
    #1 ra[0] = ADC_ADDR_TEMP; ra[1] = ADC_ADDR_VCC; rv[0] = 1'b1; rv[1] = 1'b1;
    pen = 0;
    for (int k = 0; k < 20 && pen == 0; k++) begin
      @(negedge clk);
      if (bus.apb_penable) pen = 1;
    end
    check("t5_reached_access", 32'(pen), 32'h1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("t5_rst_strobes", 32'({bus.apb_psel, bus.apb_penable, bus.busy}), 32'h0);
    check("t5_rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    @(negedge clk);
    check("t5_rst_rsp_valid2", 32'(bus.rsp_valid), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    force_d = 0;
    @(negedge clk);
    check("t5_first_winner", 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1 rv[0] = 1'b0; rv[1] = 1'b0;
    repeat (10) @(posedge clk);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
